// File: rtl/rx_buff_pkg.sv
// -----------------------------------------------------------------------------
// rx_buff_pkg
// Shared definitions for the serial receive FIFO (rx_fifo_buff).
//   RX_IDLE_BIT : idle line level; the hold register resets to a word of these
//   rx_op_e     : per-cycle operation selected by the FIFO control decode
// -----------------------------------------------------------------------------
package rx_buff_pkg;

    localparam logic RX_IDLE_BIT = 1'b1;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_PUSH_POP,
        OP_DROP,
        OP_FLUSH
    } rx_op_e;

endpackage

// File: rtl/rx_fifo_mem.sv
// -----------------------------------------------------------------------------
// rx_fifo_mem
// DEPTH x DATA_WIDTH register array. There is one synchronous write port and one
// asynchronous read port. The storage has no reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module rx_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/rx_fifo_buff.sv
// -----------------------------------------------------------------------------
// rx_fifo_buff
// Show-ahead receive FIFO between the RX packet assembler and the APB RX data
// register. When the FIFO is full, an incoming word is dropped and a sticky
// overrun flag is set.
//   clk           : system clock
//   rst           : synchronous active-high reset
//   load_buffer   : push packet_data (one-cycle strobe)
//   packet_data   : received word
//   data_read     : pop the head entry
//   flush         : discard contents and clear overrun
//   rx_data       : head entry; when empty, last word delivered (all ones after reset)
//   data_ready    : FIFO non-empty
//   overrun_error : sticky drop-on-full flag
//   count         : occupancy 0..DEPTH
//   almost_full   : count >= AF_LEVEL
// -----------------------------------------------------------------------------
module rx_fifo_buff
    import rx_buff_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned AF_LEVEL   = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_buffer,
    input  logic [DATA_WIDTH-1:0]      packet_data,
    input  logic                       data_read,
    input  logic                       flush,
    output logic [DATA_WIDTH-1:0]      rx_data,
    output logic                       data_ready,
    output logic                       overrun_error,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overrun;
    logic [DATA_WIDTH-1:0] r_hold;

    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_we;
    rx_op_e                w_op;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);

    // Priority order: flush, then push+pop, then drop, then push, then pop.
    // A read on an empty FIFO is treated as absent, so load+read while empty
    // becomes a plain push.
    always_comb begin
        w_op = OP_IDLE;
        if (flush) begin
            w_op = OP_FLUSH;
        end else if (load_buffer && data_read && !w_empty) begin
            w_op = OP_PUSH_POP;
        end else if (load_buffer && w_full) begin
            w_op = OP_DROP;
        end else if (load_buffer) begin
            w_op = OP_PUSH;
        end else if (data_read && !w_empty) begin
            w_op = OP_POP;
        end
    end

    assign w_we = !rst && ((w_op == OP_PUSH) || (w_op == OP_PUSH_POP));

    rx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wr_ptr),
        .wdata (packet_data),
        .raddr (r_rd_ptr),
        .rdata (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_hold    <= {DATA_WIDTH{RX_IDLE_BIT}};
        end else begin
            case (w_op)
                OP_FLUSH: begin
                    r_wr_ptr  <= '0;
                    r_rd_ptr  <= '0;
                    r_count   <= '0;
                    r_overrun <= 1'b0;
                end
                OP_PUSH: begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_count  <= r_count + CW'(1);
                end
                OP_POP: begin
                    r_rd_ptr  <= r_rd_ptr + 1'b1;
                    r_count   <= r_count - CW'(1);
                    r_hold    <= w_head;
                    r_overrun <= 1'b0;
                end
                OP_PUSH_POP: begin
                    r_wr_ptr  <= r_wr_ptr + 1'b1;
                    r_rd_ptr  <= r_rd_ptr + 1'b1;
                    r_hold    <= w_head;
                    r_overrun <= 1'b0;
                end
                OP_DROP: begin
                    r_overrun <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign rx_data       = w_empty ? r_hold : w_head;
    assign data_ready    = !w_empty;
    assign overrun_error = r_overrun;
    assign count         = r_count;
    assign almost_full   = (r_count >= AF_C);

endmodule

// File: tb/tb_rx_fifo_buff.sv
module tb_rx_fifo_buff;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_buffer = 1'b0;
    logic [7:0] packet_data = '0;
    logic       data_read = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       overrun_error;
    logic [2:0] count;
    logic       almost_full;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: scoreboard queue of stored words plus flags.
    logic [7:0] sb_q[$];
    logic [7:0] m_hold = 8'hFF;
    logic       m_ovr  = 1'b0;

    always #5 clk = ~clk;

    rx_fifo_buff #(
        .DATA_WIDTH (8),
        .DEPTH      (4),
        .AF_LEVEL   (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_buffer   (load_buffer),
        .packet_data   (packet_data),
        .data_read     (data_read),
        .flush         (flush),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .count         (count),
        .almost_full   (almost_full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] exp_data;
        exp_data = (sb_q.size() != 0) ? sb_q[0] : m_hold;
        check({tag, ".count"},   32'(count),         32'(sb_q.size()));
        check({tag, ".ready"},   32'(data_ready),    32'(sb_q.size() != 0));
        check({tag, ".ovr"},     32'(overrun_error), 32'(m_ovr));
        check({tag, ".af"},      32'(almost_full),   32'(sb_q.size() >= 3));
        check({tag, ".rx_data"}, 32'(rx_data),       32'(exp_data));
    endtask

    // One clock cycle: drive, update the model at the edge, then sample.
    task automatic step(input string tag, input logic ld, input logic [7:0] d,
                        input logic rd, input logic fl, input logic rs);
        bit can_pop;
        bit can_push;
        load_buffer = ld;
        packet_data = d;
        data_read   = rd;
        flush       = fl;
        rst         = rs;
        @(posedge clk);
        if (rs) begin
            sb_q.delete();
            m_ovr  = 1'b0;
            m_hold = 8'hFF;
        end else if (fl) begin
            sb_q.delete();
            m_ovr = 1'b0;
        end else begin
            can_pop  = rd && (sb_q.size() != 0);
            can_push = ld && ((sb_q.size() < 4) || can_pop);
            if (ld && !can_push) m_ovr = 1'b1;
            if (can_pop) begin
                m_hold = sb_q.pop_front();
                m_ovr  = 1'b0;
            end
            if (can_push) sb_q.push_back(d);
        end
        #1;
        load_buffer = 1'b0;
        data_read   = 1'b0;
        flush       = 1'b0;
        rst         = 1'b0;
        check_outputs(tag);
    endtask

    task automatic push(input string tag, input logic [7:0] d);
        step(tag, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop(input string tag);
        step(tag, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #1;
        // Reset then idle
        step("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("reset.rx_ff", 32'(rx_data), 32'h0000_00FF);
        step("idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Basic fill and drain
        push("p1", 8'hA1);
        push("p2", 8'hB2);
        push("p3", 8'hC3);
        check("af3", 32'(almost_full), 32'd1);
        for (int i = 0; i < 3; i++) pop("drain1");
        check("hold_c3", 32'(rx_data), 32'h0000_00C3);

        // Overrun: fifth push dropped
        push("f1", 8'h11);
        push("f2", 8'h22);
        push("f3", 8'h33);
        push("f4", 8'h44);
        push("ovr", 8'h55);
        check("ovr_set", 32'(overrun_error), 32'd1);
        pop("ovr_pop");
        check("ovr_clr", 32'(overrun_error), 32'd0);
        for (int i = 0; i < 3; i++) pop("drain2");
        check("no55", 32'(rx_data), 32'h0000_0044);

        // Full with simultaneous push and pop
        push("g1", 8'h11);
        push("g2", 8'h22);
        push("g3", 8'h33);
        push("g4", 8'h44);
        step("full_pp", 1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
        check("full_pp.cnt", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) pop("drain3");
        check("last66", 32'(rx_data), 32'h0000_0066);

        // Pointer wrap: steady push/pop, then random traffic
        push("w0", 8'h01);
        for (int i = 0; i < 10; i++)
            step("wrap", 1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++)
            step("rand", 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), 1'b0);
        for (int i = 0; i < 4; i++) pop("drain4");

        // Empty: read+load together becomes a push; read alone is ignored
        step("empty_rl", 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        check("empty_rl.rx", 32'(rx_data), 32'h0000_0077);
        pop("pop77");
        pop("empty_rd");
        check("empty_rd.rx", 32'(rx_data), 32'h0000_0077);

        // Flush beats load; overrun cleared; hold kept
        push("h1", 8'hD1);
        push("h2", 8'hD2);
        push("h3", 8'hD3);
        push("h4", 8'hD4);
        push("h_ovr", 8'hD5);
        step("flush", 1'b1, 8'h88, 1'b0, 1'b1, 1'b0);
        check("flush.rx", 32'(rx_data), 32'h0000_0077);
        push("after_flush", 8'h99);

        // Reset mid-stream
        push("r2", 8'h9A);
        step("mid_rst", 1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
        check("mid_rst.rx", 32'(rx_data), 32'h0000_00FF);
        push("post_rst", 8'h5A);
        pop("post_rst_pop");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
